// File: rtl/ysyx_24100012_lsu.sv
// rtl/ysyx_24100012_lsu.sv - load/store unit: request check, single RAM access, extended response
module ysyx_24100012_lsu #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] ORIGIN_ADDR = 32'h80000000,
  parameter logic [ADDR_WIDTH-1:0] MEM_SIZE    = 32'h08000000,
  parameter int                    TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_len,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  function automatic logic [3:0] len_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   len_of = 4'd1;
      2'b01:   len_of = 4'd2;
      default: len_of = 4'd4;
    endcase
  endfunction

  logic [3:0]            req_len;
  logic [ADDR_WIDTH:0]   req_end;
  logic [ADDR_WIDTH:0]   win_end;
  logic                  req_fault;
  logic [DATA_WIDTH-1:0] req_wdata_masked;
  logic [DATA_WIDTH-1:0] ext_rdata;
  logic                  in_access;
  logic                  in_resp;

  assign req_len = len_of(req_funct3);
  // Window bound is checked one bit wider so a request near the top of the address space cannot wrap into range.
  assign req_end = {1'b0, req_addr} + {{(ADDR_WIDTH-3){1'b0}}, req_len};
  assign win_end = {1'b0, ORIGIN_ADDR} + {1'b0, MEM_SIZE};

  always_comb begin
    req_fault = 1'b0;
    if ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111)) req_fault = 1'b1;
    if (req_we && req_funct3[2]) req_fault = 1'b1;
    if ((req_len == 4'd2) && req_addr[0]) req_fault = 1'b1;
    if ((req_len == 4'd4) && (req_addr[1:0] != 2'b00)) req_fault = 1'b1;
    if (req_addr < ORIGIN_ADDR) req_fault = 1'b1;
    if (req_end > win_end) req_fault = 1'b1;
  end

  always_comb begin
    case (req_len)
      4'd1:    req_wdata_masked = {{(DATA_WIDTH-8){1'b0}}, req_wdata[7:0]};
      4'd2:    req_wdata_masked = {{(DATA_WIDTH-16){1'b0}}, req_wdata[15:0]};
      default: req_wdata_masked = req_wdata;
    endcase
  end

  always_comb begin
    case (funct3_q)
      3'b000:  ext_rdata = {{(DATA_WIDTH-8){mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  ext_rdata = {{(DATA_WIDTH-16){mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  ext_rdata = {{(DATA_WIDTH-8){1'b0}}, mem_rdata[7:0]};
      3'b101:  ext_rdata = {{(DATA_WIDTH-16){1'b0}}, mem_rdata[15:0]};
      default: ext_rdata = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata_masked;
          cnt_d    = '0;
          rdata_d  = '0;
          err_d    = req_fault;
          state_d  = req_fault ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          rdata_d = we_q ? '0 : ext_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Outputs decode straight from the state register so reset clears them without a clock.
  assign in_access  = (state_q == ACCESS);
  assign in_resp    = (state_q == RESP);
  assign req_ready  = (state_q == IDLE);
  assign mem_ren    = in_access && !we_q;
  assign mem_wen    = in_access && we_q;
  assign mem_addr   = in_access ? addr_q : '0;
  assign mem_len    = in_access ? {{(DATA_WIDTH-4){1'b0}}, len_of(funct3_q)} : '0;
  assign mem_wdata  = in_access ? wdata_q : '0;
  assign resp_valid = in_resp;
  assign resp_rdata = in_resp ? rdata_q : '0;
  assign resp_err   = in_resp && err_q;

endmodule
